// File: rtl/sample_fifo_if.sv
// Handshake and status bundle between the sample buffer (slave) and the
// logic driving and draining it (master).
interface sample_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  flush;
  logic                  winc;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wfull;
  logic                  wafull;
  logic                  rinc;
  logic                  newout;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ADDR_WIDTH:0]   level;
  logic                  ovf;
  logic                  udf;

  modport master (
    output flush, winc, wdata, rinc,
    input  wfull, wafull, newout, rdata, level, ovf, udf
  );

  modport slave (
    input  flush, winc, wdata, rinc,
    output wfull, wafull, newout, rdata, level, ovf, udf
  );
endinterface

// File: rtl/sample_fifo.sv
// First-word-fall-through sample buffer with fill level and almost-full flag.
// Sticky overflow/underflow flags exist only when SAMPLE_FIFO_ERRFLAG_EN is defined.
module sample_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic          i_clk,
  input  logic          i_rst,
  sample_fifo_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_LVL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_LVL = (ADDR_WIDTH+1)'(AFULL_LEVEL);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH:0]   wptr_r;
  logic [ADDR_WIDTH:0]   rptr_r;

  logic [ADDR_WIDTH:0]   level_s;
  logic                  wfull_s;
  logic                  wafull_s;
  logic                  newout_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic [DATA_WIDTH-1:0] rdata_s;

  // Status decode from registered pointers; accepts are masked by flush.
  always_comb begin
    level_s  = wptr_r - rptr_r;
    wfull_s  = (level_s == DEPTH_LVL);
    wafull_s = (level_s >= AFULL_LVL);
    newout_s = (level_s != {(ADDR_WIDTH+1){1'b0}});
    wr_acc_s = bus.winc && !wfull_s && !bus.flush;
    rd_acc_s = bus.rinc && newout_s && !bus.flush;
  end

  // Head sample, forced to zero while the buffer is empty.
  always_comb begin
    rdata_s = {DATA_WIDTH{1'b0}};
    if (newout_s) begin
      rdata_s = mem_r[rptr_r[ADDR_WIDTH-1:0]];
    end else begin
      rdata_s = {DATA_WIDTH{1'b0}};
    end
  end

  // Storage array; intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (wr_acc_s) begin
      mem_r[wptr_r[ADDR_WIDTH-1:0]] <= bus.wdata;
    end
  end

  // Pointer update; flush discards contents by catching rptr up to wptr.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wptr_r <= {(ADDR_WIDTH+1){1'b0}};
      rptr_r <= {(ADDR_WIDTH+1){1'b0}};
    end else if (bus.flush) begin
      rptr_r <= wptr_r;
    end else begin
      if (wr_acc_s) begin
        wptr_r <= wptr_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
      end
      if (rd_acc_s) begin
        rptr_r <= rptr_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
      end
    end
  end

`ifdef SAMPLE_FIFO_ERRFLAG_EN
  logic ovf_r;
  logic udf_r;

  // Sticky error flags, cleared only by reset (flush leaves them alone).
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      if (bus.winc && wfull_s) begin
        ovf_r <= 1'b1;
      end
      if (bus.rinc && !newout_s) begin
        udf_r <= 1'b1;
      end
    end
  end

  assign bus.ovf = ovf_r;
  assign bus.udf = udf_r;
`else
  assign bus.ovf = 1'b0;
  assign bus.udf = 1'b0;
`endif

  assign bus.level  = level_s;
  assign bus.wfull  = wfull_s;
  assign bus.wafull = wafull_s;
  assign bus.newout = newout_s;
  assign bus.rdata  = rdata_s;

endmodule

// File: tb/tb_sample_fifo.sv
// Scoreboard bench for sample_fifo: a queue holds the expected contents and
// every cycle the outputs are compared against it.
module tb_sample_fifo;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;
`ifdef SAMPLE_FIFO_ERRFLAG_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic i_clk;
  logic i_rst;

  sample_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sample_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AFULL_LEVEL(AFULL)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  int total;
  int bad;
  logic [DW-1:0] exp_q [$];
  bit ovf_m;
  bit udf_m;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int sz;
    logic [DW-1:0] head;
    sz   = exp_q.size();
    head = (sz > 0) ? exp_q[0] : 32'h0000_0000;
    check_val("level",  64'(bus.level),  64'(sz));
    check_val("newout", 64'(bus.newout), 64'(sz != 0));
    check_val("wfull",  64'(bus.wfull),  64'(sz == DEPTH));
    check_val("wafull", 64'(bus.wafull), 64'(sz >= AFULL));
    check_val("rdata",  64'(bus.rdata),  64'(head));
    check_val("ovf",    64'(bus.ovf),    64'(ovf_m));
    check_val("udf",    64'(bus.udf),    64'(udf_m));
  endtask

  // One clock cycle of stimulus; the model is updated from the pre-edge state.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
    int sz;
    bus.winc  = w;
    bus.wdata = d;
    bus.rinc  = r;
    bus.flush = f;
    sz = exp_q.size();
    if (ERR_EN && w && (sz == DEPTH)) ovf_m = 1'b1;
    if (ERR_EN && r && (sz == 0))     udf_m = 1'b1;
    if (f) begin
      exp_q.delete();
    end else begin
      if (r && (sz > 0)) void'(exp_q.pop_front());
      if (w && (sz < DEPTH)) exp_q.push_back(d);
    end
    @(posedge i_clk);
    #1;
    bus.winc  = 1'b0;
    bus.rinc  = 1'b0;
    bus.flush = 1'b0;
    check_outputs();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 3 * DEPTH) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      guard++;
    end
    check_val("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    ovf_m = 1'b0;
    udf_m = 1'b0;
    i_rst     = 1'b0;
    bus.winc  = 1'b0;
    bus.rinc  = 1'b0;
    bus.flush = 1'b0;
    bus.wdata = 32'h0;

    // Reset and empty-pop behaviour
    repeat (2) @(posedge i_clk);
    #1;
    check_outputs();
    i_rst = 1'b1;
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);

    // Fill 1..16, rejected 17th write, then in-order drain
    for (int i = 1; i <= DEPTH; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    drain();

    // Fall-through latency
    step(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
    check_val("ft_rdata", 64'(bus.rdata), 64'h0000_0000_A5A5_A5A5);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check_val("ft_empty", 64'(bus.newout), 64'd0);

    // Steady simultaneous read/write at level 8 across pointer wrap
    for (int i = 0; i < 8; i++) step(1'b1, 32'h0000_0100 + DW'(i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 32'h0000_0200 + DW'(i), 1'b1, 1'b0);

    // Full with simultaneous read: write must be dropped
    for (int i = 0; i < 8; i++) step(1'b1, 32'h0000_0300 + DW'(i), 1'b0, 1'b0);
    step(1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0);
    check_val("full_rw_level", 64'(bus.level), 64'd15);
    drain();

    // Flush overrides a same-cycle write
    for (int i = 0; i < 5; i++) step(1'b1, 32'h0000_0400 + DW'(i), 1'b0, 1'b0);
    step(1'b1, 32'h5555_5555, 1'b0, 1'b1);
    check_val("flush_level", 64'(bus.level), 64'd0);

    // Asynchronous reset between edges
    for (int i = 0; i < 3; i++) step(1'b1, 32'h0000_0500 + DW'(i), 1'b0, 1'b0);
    #3;
    i_rst = 1'b0;
    #1;
    exp_q.delete();
    ovf_m = 1'b0;
    udf_m = 1'b0;
    check_outputs();
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    step(1'b1, 32'h0000_0077, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
